// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the 4-bit ALU and its command sequencer.
//   ALU_W        : datapath width of the ALU (fixed at 4)
//   alu_op_e     : 3-bit ALU operation encoding, 111 reserved as illegal
//   seq_state_e  : sequencer FSM states
//   op_is_legal  : helper that tells whether an opcode produces a result
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_OR      = 3'b011,
        OP_XOR     = 3'b100,
        OP_PASS_A  = 3'b101,
        OP_PASS_B  = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } seq_state_e;

    // The only opcode that does not produce a real result is the reserved one.
    function automatic logic op_is_legal(input alu_op_e op);
        return (op != OP_ILLEGAL);
    endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational ALU. ADD and SUB wrap modulo 2^WIDTH; there is no
// carry or borrow output. The reserved opcode yields zero.
// Ports:
//   a      [WIDTH-1:0] in  : operand A
//   b      [WIDTH-1:0] in  : operand B
//   op     alu_op_e    in  : operation select
//   result [WIDTH-1:0] out : operation result
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result
);

    // Operation decode. Arithmetic results are simply truncated to WIDTH
    // bits, which gives the modulo wrap-around without extra logic.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Command-side initiator for the combinational alu. A command is taken over a
// valid/ready handshake, its operands are registered and fed to the ALU, the
// result is captured one cycle later and returned over a valid/ready response
// channel together with zero and error flags.
//
// Optional feature macro: ALU_SEQ_ACC_EN
//   defined   : an accumulator tracks the last legal result; cmd_src=1 takes
//               operand A from it, and the acc port shows its value
//   undefined : no accumulator; cmd_src is ignored and acc is tied to zero
//
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset
//   cmd_valid  in  : command present
//   cmd_ready  out : sequencer can accept a command (IDLE only)
//   cmd_op     in  : 3-bit opcode (see alu_pkg::alu_op_e)
//   cmd_a      in  : operand A
//   cmd_b      in  : operand B
//   cmd_src    in  : 0 = A from cmd_a, 1 = A from accumulator
//   rsp_valid  out : response present (RESP only)
//   rsp_ready  in  : consumer accepts the response
//   rsp_result out : captured ALU result
//   rsp_zero   out : rsp_result is zero
//   rsp_err    out : command used the reserved opcode
//   acc        out : current accumulator value
// ----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_src,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc
);

    seq_state_e       state;
    seq_state_e       state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] alu_result;
    logic             cmd_accept;
    logic             op_legal;
    logic [WIDTH-1:0] acc_value;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign op_legal   = op_is_legal(op_q);

    // The single ALU instance always looks at the operand registers, so its
    // output is stable throughout EXEC regardless of what the host does.
    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q;

    // The accumulator follows every legal result; it is written on the same
    // edge that captures the response, so it is visible with rsp_valid and a
    // chained command issued right after the response sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (state == S_EXEC && op_legal) begin
            acc_q <= alu_result;
        end
    end

    // Operand A comes from the accumulator when the host asks for chaining.
    always_comb begin
        a_sel = cmd_src ? acc_q : cmd_a;
    end

    assign acc_value = acc_q;
`else
    logic unused_cmd_src;

    // Without an accumulator the source select has no meaning; A is always
    // taken straight from the command.
    always_comb begin
        a_sel = cmd_a;
    end

    assign unused_cmd_src = cmd_src;
    assign acc_value      = '0;
`endif

    assign acc = acc_value;

    // State register. Reset from any state returns to IDLE, which drops an
    // in-flight command without ever producing its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Commands are only accepted in IDLE,
    // so a command arriving in EXEC or RESP simply waits at the host; the
    // response handshake is only meaningful in RESP.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand registers. They load only on an accepted command and otherwise
    // hold, which keeps the ALU inputs steady through EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else if (cmd_accept) begin
            a_q  <= a_sel;
            b_q  <= cmd_b;
            op_q <= alu_op_e'(cmd_op);
        end
    end

    // Response registers. They are written only at the end of EXEC, so they
    // cannot change while RESP waits for rsp_ready. The reserved opcode forces
    // a zero result with both zero and error flags set.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (state == S_EXEC) begin
            if (op_legal) begin
                rsp_result <= alu_result;
                rsp_zero   <= (alu_result == '0);
                rsp_err    <= 1'b0;
            end else begin
                rsp_result <= '0;
                rsp_zero   <= 1'b1;
                rsp_err    <= 1'b1;
            end
        end
    end

endmodule
